// File: rtl/wght_fetch_ctrl_if.sv
// Weight fetch controller bus: burst request/status, weight memory read port,
// output stream handshake and stall counter. The slave side is the controller.
interface wght_fetch_ctrl_if #(
    parameter int WIDTH      = 512,
    parameter int ADDR_WIDTH = 11
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  mem_ena;
    logic                  mem_rden;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_q;
    logic                  o_valid;
    logic                  o_ready;
    logic [WIDTH-1:0]      o_data;
    logic                  o_last;
    logic [31:0]           stall_cnt;

    modport master (
        output start, base_addr, len, mem_q, o_ready,
        input  busy, done, err, mem_ena, mem_rden, mem_addr,
               o_valid, o_data, o_last, stall_cnt
    );

    modport slave (
        input  start, base_addr, len, mem_q, o_ready,
        output busy, done, err, mem_ena, mem_rden, mem_addr,
               o_valid, o_data, o_last, stall_cnt
    );
endinterface

// File: rtl/wght_fetch_ctrl.sv
// Weight fetch controller: on start, reads len words from base_addr out of a
// one-cycle-latency weight memory and streams them through a 2-entry output
// FIFO with valid/ready handshake. Optional stall counter is enabled by
// defining WFETCH_STALL_CNT_EN; otherwise stall_cnt is tied to 0.
module wght_fetch_ctrl #(
    parameter int WIDTH      = 512,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 1536
) (
    input logic             clk,
    input logic             rst_n,
    wght_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH:0]   rd_left_q;
    logic [ADDR_WIDTH:0]   pop_left_q;
    logic                  infl_q;
    logic [WIDTH-1:0]      fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  done_q, err_q;

    logic                  start_ok, range_bad, go, pop, issue, busy_w, o_valid_w;
    logic [ADDR_WIDTH+1:0] end_addr;
    logic [2:0]            occ_sum;

    assign start_ok  = bus.start && (state_q == IDLE);
    assign end_addr  = {2'b00, bus.base_addr} + {1'b0, bus.len};
    assign range_bad = end_addr > DEPTH_W;
    assign go        = start_ok && !range_bad && (bus.len != '0);
    assign o_valid_w = (cnt_q != 2'd0);
    assign pop       = o_valid_w && bus.o_ready;
    // A pop needs a stored word, so this sum never underflows.
    assign occ_sum   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = FETCH;
            FETCH:   if (issue && (rd_left_q == (ADDR_WIDTH+1)'(1))) state_d = DRAIN;
            DRAIN:   if (pop && (pop_left_q == (ADDR_WIDTH+1)'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: read only if the word still fits once everything in flight lands
    always_comb begin
        busy_w = (state_q != IDLE);
        issue  = 1'b0;
        if ((state_q == FETCH) && (occ_sum < 3'd2)) issue = 1'b1;
    end

    // Burst counters, read pipeline and output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            pop_left_q <= '0;
            infl_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (go) begin
                rd_addr_q  <= bus.base_addr;
                rd_left_q  <= bus.len;
                pop_left_q <= bus.len;
            end else begin
                if (issue) begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    rd_left_q <= rd_left_q - 1'b1;
                end
                if (pop) pop_left_q <= pop_left_q - 1'b1;
            end
            infl_q <= issue;
            if (infl_q) begin
                fifo_q[wr_ptr_q] <= bus.mem_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({infl_q, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
            done_q <= (start_ok && !range_bad && (bus.len == '0)) ||
                      ((state_q == DRAIN) && pop && (pop_left_q == (ADDR_WIDTH+1)'(1)));
            err_q  <= start_ok && range_bad;
        end
    end

    assign bus.busy     = busy_w;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.mem_ena  = issue;
    assign bus.mem_rden = issue;
    assign bus.mem_addr = issue ? rd_addr_q : '0;
    assign bus.o_valid  = o_valid_w;
    assign bus.o_data   = fifo_q[rd_ptr_q];
    assign bus.o_last   = o_valid_w && (pop_left_q == (ADDR_WIDTH+1)'(1));

`ifdef WFETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles where a burst's output word is held back by the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         stall_q <= '0;
        else if (start_ok)                                  stall_q <= '0;
        else if (busy_w && o_valid_w && !bus.o_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_wght_fetch_ctrl.sv
// Self-checking bench for wght_fetch_ctrl with a behavioural memory and a
// burst reference model (address order, last flag, timing rules).
module tb_wght_fetch_ctrl;
    localparam int W     = 64;
    localparam int AW    = 11;
    localparam int DEPTH = 1536;
`ifdef WFETCH_STALL_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wght_fetch_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    wght_fetch_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [W-1:0] word_at(int unsigned a);
        logic [31:0] x;
        x = a * 32'h9E3779B9 + 32'h7F4A7C15;
        return {x, ~x ^ a};
    endfunction

    // Memory with one-cycle read latency; output is garbage when not read
    always @(posedge clk) begin
        if (bus.mem_ena && bus.mem_rden) bus.mem_q <= word_at(32'(bus.mem_addr));
        else                             bus.mem_q <= {$urandom, $urandom};
    end

    logic [W-1:0] obs_data[$];
    bit           obs_last[$];
    int unsigned  rd_addrs[$];
    int first_rd, last_rd, first_vld, last_hs, done_cyc, err_cyc, err_cnt;
    int busy_cyc, max_out, unstable, strobe_bad;
    bit busy_at_done;

    function automatic bit rdy(int mode, int c);
        case (mode)
            1:       return (c % 2) == 1;
            2:       return 1'($urandom_range(0, 1));
            3:       return c >= 8;
            default: return 1'b1;
        endcase
    endfunction

    // Drives one start and records what the DUT does; makes no judgement
    task automatic drive_burst(input int unsigned b, input int unsigned l, input int mode,
                               input int maxc, input int inj);
        int issued, popped;
        bit prev_stall;
        logic [W-1:0] prev_data;
        bit prev_last;
        obs_data.delete(); obs_last.delete(); rd_addrs.delete();
        first_rd = -1; last_rd = -1; first_vld = -1; last_hs = -1; done_cyc = -1;
        err_cyc = -1; err_cnt = 0; busy_cyc = 0; max_out = 0; unstable = 0; strobe_bad = 0;
        busy_at_done = 1'b0; issued = 0; popped = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = AW'(b); bus.len = (AW+1)'(l); bus.o_ready = rdy(mode, 0);
        @(negedge clk);
        for (int c = 1; c <= maxc; c++) begin
            bus.o_ready = rdy(mode, c);
            if (c == inj) begin bus.start = 1'b1; bus.base_addr = '0; bus.len = 3; end
            else bus.start = 1'b0;
            #1;
            if (bus.mem_ena !== bus.mem_rden) strobe_bad++;
            if (bus.mem_rden) begin
                rd_addrs.push_back(32'(bus.mem_addr)); issued++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (bus.o_valid && first_vld < 0) first_vld = c;
            if (prev_stall && (!bus.o_valid || bus.o_data !== prev_data || bus.o_last !== prev_last)) unstable++;
            if (bus.o_valid && bus.o_ready) begin
                obs_data.push_back(bus.o_data); obs_last.push_back(bus.o_last); popped++; last_hs = c;
            end
            prev_stall = bus.o_valid && !bus.o_ready;
            prev_data = bus.o_data; prev_last = bus.o_last;
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.busy) busy_cyc++;
            if (bus.err) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
            if (bus.done) begin done_cyc = c; busy_at_done = bus.busy; break; end
            @(negedge clk);
        end
        bus.start = 1'b0; bus.o_ready = 1'b1;
    endtask

    // Reference model differences: expected stream is word_at(b+i), i < l
    function automatic int word_errs(int unsigned b, int unsigned l);
        int e = (obs_data.size() != l) ? 1 : 0;
        for (int unsigned i = 0; i < l && i < obs_data.size(); i++)
            if (obs_data[i] !== word_at(b + i)) e++;
        return e;
    endfunction

    function automatic int last_errs(int unsigned l);
        int e = (obs_last.size() != l) ? 1 : 0;
        for (int unsigned i = 0; i < obs_last.size(); i++)
            if (obs_last[i] !== (i == l - 1)) e++;
        return e;
    endfunction

    function automatic int addr_errs(int unsigned b, int unsigned l);
        int e = (rd_addrs.size() != l) ? 1 : 0;
        for (int unsigned i = 0; i < l && i < rd_addrs.size(); i++)
            if (rd_addrs[i] != b + i) e++;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.o_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.busy, bus.done, bus.err, bus.mem_ena, bus.mem_rden, bus.o_valid, bus.o_last} !== 7'd0) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {bus.busy, bus.done, bus.err, bus.mem_ena, bus.mem_rden, bus.o_valid, bus.o_last}); end
        n_checks++; if (bus.o_data !== '0) begin n_errors++; $display("FAIL reset_o_data: got %h expected 0", bus.o_data); end
        n_checks++; if (bus.mem_addr !== '0) begin n_errors++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
        n_checks++; if (bus.stall_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive_burst(0, 4, 0, 20, -1);
        n_checks++; if (first_rd !== 1 || last_rd !== 4) begin n_errors++; $display("FAIL basic_read_cycles: got %0d..%0d expected 1..4", first_rd, last_rd); end
        n_checks++; if (addr_errs(0, 4) !== 0) begin n_errors++; $display("FAIL basic_addr: got %0d bad expected 0", addr_errs(0, 4)); end
        n_checks++; if (first_vld !== 3 || last_hs !== 6) begin n_errors++; $display("FAIL basic_valid_cycles: got %0d..%0d expected 3..6", first_vld, last_hs); end
        n_checks++; if (word_errs(0, 4) !== 0) begin n_errors++; $display("FAIL basic_data: got %0d bad expected 0", word_errs(0, 4)); end
        n_checks++; if (last_errs(4) !== 0) begin n_errors++; $display("FAIL basic_last: got %0d bad expected 0", last_errs(4)); end
        n_checks++; if (done_cyc !== 7 || busy_at_done !== 1'b0) begin n_errors++; $display("FAIL basic_done: got cycle %0d busy %0d expected cycle 7 busy 0", done_cyc, busy_at_done); end
        n_checks++; if (busy_cyc !== 6) begin n_errors++; $display("FAIL basic_busy_span: got %0d expected 6", busy_cyc); end
        n_checks++; if (strobe_bad !== 0) begin n_errors++; $display("FAIL basic_strobes: got %0d bad expected 0", strobe_bad); end
    endtask

    task automatic test_backpressure();
        int unsigned b = $urandom_range(0, DEPTH - 8);
        drive_burst(b, 8, 1, 60, -1);
        n_checks++; if (word_errs(b, 8) !== 0) begin n_errors++; $display("FAIL bp_data: got %0d bad expected 0", word_errs(b, 8)); end
        n_checks++; if (last_errs(8) !== 0) begin n_errors++; $display("FAIL bp_last: got %0d bad expected 0", last_errs(8)); end
        n_checks++; if (addr_errs(b, 8) !== 0) begin n_errors++; $display("FAIL bp_addr: got %0d bad expected 0", addr_errs(b, 8)); end
        n_checks++; if (max_out > 2) begin n_errors++; $display("FAIL bp_outstanding: got %0d expected <=2", max_out); end
        n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL bp_hold: got %0d changes expected 0", unstable); end
        n_checks++; if (done_cyc !== last_hs + 1 || busy_at_done !== 1'b0) begin n_errors++; $display("FAIL bp_done: got cycle %0d busy %0d expected cycle %0d busy 0", done_cyc, busy_at_done, last_hs + 1); end
    endtask

    task automatic test_range();
        drive_burst(1530, 7, 0, 6, -1);
        n_checks++; if (err_cyc !== 1 || err_cnt !== 1) begin n_errors++; $display("FAIL range_err: got cycle %0d count %0d expected cycle 1 count 1", err_cyc, err_cnt); end
        n_checks++; if (rd_addrs.size() !== 0 || busy_cyc !== 0) begin n_errors++; $display("FAIL range_no_read: got reads %0d busy %0d expected 0 0", rd_addrs.size(), busy_cyc); end
        n_checks++; if (done_cyc !== -1) begin n_errors++; $display("FAIL range_no_done: got %0d expected -1", done_cyc); end
        drive_burst(1530, 6, 0, 30, -1);
        n_checks++; if (word_errs(1530, 6) !== 0) begin n_errors++; $display("FAIL range_fit_data: got %0d bad expected 0", word_errs(1530, 6)); end
        n_checks++; if (done_cyc !== 9 || err_cnt !== 0) begin n_errors++; $display("FAIL range_fit_done: got cycle %0d err %0d expected 9 0", done_cyc, err_cnt); end
    endtask

    task automatic test_len0_and_ignore();
        drive_burst(100, 0, 0, 5, -1);
        n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL len0_done: got %0d expected 1", done_cyc); end
        n_checks++; if (rd_addrs.size() !== 0 || busy_cyc !== 0 || obs_data.size() !== 0) begin n_errors++; $display("FAIL len0_quiet: got reads %0d busy %0d words %0d expected 0 0 0", rd_addrs.size(), busy_cyc, obs_data.size()); end
        drive_burst(200, 8, 0, 30, 4);
        n_checks++; if (word_errs(200, 8) !== 0) begin n_errors++; $display("FAIL ignore_data: got %0d bad expected 0", word_errs(200, 8)); end
        n_checks++; if (done_cyc !== 11 || rd_addrs.size() !== 8) begin n_errors++; $display("FAIL ignore_done: got cycle %0d reads %0d expected 11 8", done_cyc, rd_addrs.size()); end
    endtask

    task automatic test_reset_mid();
        int quiet = 0;
        int unsigned b = $urandom_range(0, DEPTH - 8);
        int unsigned b2 = $urandom_range(0, DEPTH - 8);
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = AW'(b); bus.len = 8; bus.o_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.busy, bus.done, bus.err, bus.mem_ena, bus.mem_rden, bus.o_valid, bus.o_last} !== 7'd0) begin n_errors++; $display("FAIL midrst_ctrl: got %b expected 0000000", {bus.busy, bus.done, bus.err, bus.mem_ena, bus.mem_rden, bus.o_valid, bus.o_last}); end
        n_checks++; if (bus.o_data !== '0 || bus.mem_addr !== '0) begin n_errors++; $display("FAIL midrst_data: got %h addr %0d expected 0 0", bus.o_data, bus.mem_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            #1; if (bus.done || bus.o_valid || bus.busy) quiet++;
            @(negedge clk);
        end
        n_checks++; if (quiet !== 0) begin n_errors++; $display("FAIL midrst_after: got %0d active cycles expected 0", quiet); end
        drive_burst(b2, 8, 2, 60, -1);
        n_checks++; if (word_errs(b2, 8) !== 0 || last_errs(8) !== 0) begin n_errors++; $display("FAIL midrst_new_burst: got %0d/%0d bad expected 0/0", word_errs(b2, 8), last_errs(8)); end
        n_checks++; if (done_cyc !== last_hs + 1) begin n_errors++; $display("FAIL midrst_new_done: got %0d expected %0d", done_cyc, last_hs + 1); end
    endtask

    task automatic test_stall();
        int unsigned b = $urandom_range(0, DEPTH - 4);
        drive_burst(b, 4, 3, 40, -1);
        n_checks++; if (bus.stall_cnt !== 32'(EXP_STALL)) begin n_errors++; $display("FAIL stall_cnt: got %0d expected %0d", bus.stall_cnt, EXP_STALL); end
        n_checks++; if (word_errs(b, 4) !== 0 || unstable !== 0) begin n_errors++; $display("FAIL stall_data: got %0d bad %0d changes expected 0 0", word_errs(b, 4), unstable); end
        drive_burst(b, 2, 0, 20, -1);
        n_checks++; if (bus.stall_cnt !== 32'd0) begin n_errors++; $display("FAIL stall_clear: got %0d expected 0", bus.stall_cnt); end
    endtask

    task automatic test_random();
        for (int unsigned it = 0; it < 25; it++) begin
            int unsigned b, l;
            int kind = $urandom_range(0, 5);
            if (kind == 0) begin b = $urandom_range(0, DEPTH); l = 0; end
            else if (kind == 1) begin b = $urandom_range(DEPTH - 16, DEPTH - 1); l = DEPTH - b + $urandom_range(1, 8); end
            else if (kind == 2) begin l = $urandom_range(1, 20); b = DEPTH - l; end
            else begin b = $urandom_range(0, DEPTH - 24); l = $urandom_range(1, 24); end
            if (b + l > DEPTH) begin
                drive_burst(b, l, 2, 4, -1);
                n_checks++; if (err_cyc !== 1 || rd_addrs.size() !== 0 || done_cyc !== -1) begin n_errors++; $display("FAIL rnd_err b=%0d l=%0d: got err %0d reads %0d done %0d expected 1 0 -1", b, l, err_cyc, rd_addrs.size(), done_cyc); end
            end else if (l == 0) begin
                drive_burst(b, l, 2, 4, -1);
                n_checks++; if (done_cyc !== 1 || rd_addrs.size() !== 0 || err_cnt !== 0) begin n_errors++; $display("FAIL rnd_len0 b=%0d: got done %0d reads %0d err %0d expected 1 0 0", b, done_cyc, rd_addrs.size(), err_cnt); end
            end else begin
                drive_burst(b, l, 2, 4 * int'(l) + 20, -1);
                n_checks++; if (word_errs(b, l) !== 0 || last_errs(l) !== 0 || addr_errs(b, l) !== 0) begin n_errors++; $display("FAIL rnd_stream b=%0d l=%0d: got %0d/%0d/%0d bad expected 0/0/0", b, l, word_errs(b, l), last_errs(l), addr_errs(b, l)); end
                n_checks++; if (max_out > 2 || unstable !== 0) begin n_errors++; $display("FAIL rnd_flow b=%0d l=%0d: got outstanding %0d changes %0d expected <=2 0", b, l, max_out, unstable); end
                n_checks++; if (done_cyc !== last_hs + 1 || busy_at_done !== 1'b0 || busy_cyc !== last_hs) begin n_errors++; $display("FAIL rnd_done b=%0d l=%0d: got done %0d busy %0d span %0d expected %0d 0 %0d", b, l, done_cyc, busy_at_done, busy_cyc, last_hs + 1, last_hs); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_range();
        test_len0_and_ignore();
        test_reset_mid();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
